// File: rtl/q_8_42_ones_sched.sv
// Round-robin scheduler sharing one count-ones engine between N_REQ clients.
// Grants in IDLE, launches the engine, tracks its rdy handshake and returns the count.
module q_8_42_ones_sched #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        done,
  output logic [CNT_W-1:0]        result,
  output logic                    busy,
  output logic                    cu_start,
  output logic [DATA_W-1:0]       cu_data,
  input  logic                    cu_rdy,
  input  logic [CNT_W-1:0]        cu_count,
  output logic                    proto_err
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0] cu_data_q, cu_data_d;
  logic [CNT_W-1:0]  result_q, result_d;
  logic              perr_q, perr_d;
  logic              run_q;

  logic              arb_found;
  logic [ID_W-1:0]   arb_id;
  logic              grant_ok;

  // First requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_id    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!arb_found && req[idx]) begin
        arb_found = 1'b1;
        arb_id    = ID_W'(idx);
      end else begin
        arb_found = arb_found;
      end
    end
  end

  // run_q keeps the grant path quiet while reset is asserted and for one cycle after.
  assign grant_ok = (state_q == S_IDLE) && run_q && cu_rdy && arb_found;

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    cu_data_d = cu_data_q;
    result_d  = result_q;
    perr_d    = perr_q;
    ack       = '0;
    done      = '0;
    cu_start  = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (grant_ok) begin
          ack[arb_id] = 1'b1;
          grant_d     = arb_id;
          cu_data_d   = req_data[arb_id*DATA_W +: DATA_W];
          state_d     = S_START;
        end else begin
          busy = 1'b0;
        end
      end
      S_START: begin
        cu_start = 1'b1;
        state_d  = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (cu_rdy) begin
          perr_d = 1'b1;
        end else begin
          perr_d = perr_q;
        end
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (cu_rdy) begin
          result_d = cu_count;
          state_d  = S_DONE;
        end else begin
          state_d = S_WAIT_HI;
        end
      end
      S_DONE: begin
        done[grant_q] = 1'b1;
        if (grant_q == ID_W'(N_REQ - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = grant_q + 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      cu_data_q <= '0;
      result_q  <= '0;
      perr_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      cu_data_q <= cu_data_d;
      result_q  <= result_d;
      perr_q    <= perr_d;
      run_q     <= 1'b1;
    end
  end

  assign cu_data   = cu_data_q;
  assign result    = result_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_q_8_42_ones_sched.sv
// Directed bench for q_8_42_ones_sched with a behavioural count-ones engine
// and a scoreboard of expected {client, count} results.
module tb_q_8_42_ones_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_b;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  ack, done;
  logic [CW-1:0] result;
  logic          busy, cu_start, cu_rdy, proto_err;
  logic [DW-1:0] cu_data;
  logic [CW-1:0] cu_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            cnt;
    int            acyc;
    bit            lat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  q_8_42_ones_sched #(.N_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .req_data(req_data),
    .ack(ack), .done(done), .result(result), .busy(busy),
    .cu_start(cu_start), .cu_data(cu_data), .cu_rdy(cu_rdy),
    .cu_count(cu_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine run length: one cycle per bit up to the highest set bit, minimum one.
  function automatic int eng_k(input logic [DW-1:0] d);
    int k = 1;
    for (int i = 0; i < DW; i++) if (d[i]) k = i + 1;
    return k;
  endfunction

  logic          eng_rdy;
  int            eng_left;
  logic [DW-1:0] eng_op;
  logic          force_low = 1'b0;
  logic          no_fall   = 1'b0;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      eng_rdy  <= 1'b1;
      eng_left <= 0;
      eng_op   <= '0;
      cu_count <= '0;
    end else if (cu_start) begin
      eng_op <= cu_data;
      if (no_fall) begin
        cu_count <= CW'($countones(cu_data));
      end else begin
        eng_rdy  <= 1'b0;
        eng_left <= eng_k(cu_data);
      end
    end else if (!eng_rdy) begin
      if (eng_left <= 1) begin
        eng_rdy  <= 1'b1;
        cu_count <= CW'($countones(eng_op));
      end else begin
        eng_left <= eng_left - 1;
      end
    end
  end
  assign cu_rdy = eng_rdy & ~force_low;

  always @(negedge clk) begin
    if (rst_b) begin
      chk("excl", 32'($countones({ack, done, cu_start}) <= 1), 32'd1);
      if (sb.size() > 0 && busy && !cu_rdy) chk("cu_data_hold", 32'(cu_data), 32'(sb[0].data));
      if (done != '0) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("done_id", 32'(done), 32'(1 << mon_e.id));
          chk("result", 32'(result), 32'(mon_e.cnt));
          chk("busy_at_done", 32'(busy), 32'd1);
          if (mon_e.lat) chk("ack_to_done", 32'(cyc - mon_e.acyc), 32'd4);
        end
      end
    end
  end

  task automatic issue(input int id, input logic [DW-1:0] d);
    @(posedge clk); #1;
    req_data[id*DW +: DW] = d;
    req[id] = 1'b1;
  endtask

  task automatic await_ack(input int id, input logic [DW-1:0] d, input bit lat, input bit track);
    bit got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_id", 32'(ack), 32'(1 << id));
    chk("busy_at_ack", 32'(busy), 32'd1);
    if (track) sb.push_back('{id: id, data: d, cnt: $countones(d), acyc: cyc, lat: lat});
  endtask

  task automatic finish_job(input int span_exp);
    int n = 1;
    int starts = 0;
    @(posedge clk); #1;
    req = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (cu_start) starts++;
    end
    if (span_exp >= 0) chk("busy_span", 32'(n), 32'(span_exp));
    chk("start_pulses", 32'(starts), 32'd1);
  endtask

  initial begin
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    rst_b    = 1'b0;
    req      = '0;
    req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(cu_start), 32'd0);
    chk("rst_cu_data", 32'(cu_data), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_perr", 32'(proto_err), 32'd0);
    rst_b = 1'b1;

    // Single request, long engine run (k=8).
    issue(2, 8'hB5); await_ack(2, 8'hB5, 1'b0, 1'b1); finish_job(12);
    // Zero operand: ack to done in 4 cycles.
    issue(0, 8'h00); await_ack(0, 8'h00, 1'b1, 1'b1); finish_job(5);
    // All ones from client 3, leaves rr_ptr at 0.
    issue(3, 8'hFF); await_ack(3, 8'hFF, 1'b0, 1'b1); finish_job(12);

    // Round robin with every request held.
    @(posedge clk); #1;
    req_data = {8'h0F, 8'h07, 8'h03, 8'h01};
    req      = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      await_ack(rr_exp[i], req_data[rr_exp[i]*DW +: DW], 1'b0, 1'b1);
    end
    finish_job(-1);

    // Client 2 moves rr_ptr to 3, then 0011 must wrap to client 0.
    issue(2, 8'h55); await_ack(2, 8'h55, 1'b0, 1'b1); finish_job(11);
    @(posedge clk); #1;
    req_data[0*DW +: DW] = 8'h80;
    req_data[1*DW +: DW] = 8'h01;
    req = 4'b0011;
    await_ack(0, 8'h80, 1'b0, 1'b1); finish_job(-1);

    // Engine busy externally: no grant until cu_rdy returns.
    force_low = 1'b1;
    issue(1, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_ack_rdy_low", 32'(ack), 32'd0);
    end
    @(posedge clk); #1;
    force_low = 1'b0;
    await_ack(1, 8'h3C, 1'b0, 1'b1); finish_job(10);

    // Engine never drops rdy: proto_err sets and stays set.
    no_fall = 1'b1;
    issue(3, 8'h81); await_ack(3, 8'h81, 1'b0, 1'b1); finish_job(5);
    no_fall = 1'b0;
    chk("perr_set", 32'(proto_err), 32'd1);
    issue(1, 8'h42); await_ack(1, 8'h42, 1'b0, 1'b1); finish_job(11);
    chk("perr_sticky", 32'(proto_err), 32'd1);

    // Reset while in WAIT_HI; rr_ptr is 2 beforehand.
    issue(2, 8'hFF); await_ack(2, 8'hFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_start", 32'(cu_start), 32'd0);
    chk("mid_rst_cu_data", 32'(cu_data), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_perr", 32'(proto_err), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    req_data[0*DW +: DW] = 8'h11;
    req_data[2*DW +: DW] = 8'hF0;
    req = 4'b0101;
    await_ack(0, 8'h11, 1'b0, 1'b1); finish_job(-1);

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
